// File: rtl/ball_sequencer.sv
// ball_sequencer: serve/play/score sequencing and collision-driven ball direction control
module ball_sequencer #(
  parameter int BALL_SIZE      = 15,
  parameter int DISPLAY_WIDTH  = 639,
  parameter int DISPLAY_HEIGHT = 479,
  parameter int PADDLE_W       = 10,
  parameter int PADDLE_H       = 80,
  parameter int PADDLE_L_X     = 20,
  parameter int PADDLE_R_X     = 609,
  parameter int SERVE_TICKS    = 64,
  parameter int WIN_SCORE      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       ball_reset,
  output logic       dir_horiz,
  output logic       dir_vert,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over,
  output logic [1:0] state
);
  localparam int CW = $clog2(SERVE_TICKS);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] PH    = 11'(PADDLE_H);
  localparam logic [10:0] V_MAX = 11'(DISPLAY_HEIGHT - BALL_SIZE);
  localparam logic [10:0] H_MAX = 11'(DISPLAY_WIDTH - BALL_SIZE);
  localparam logic [10:0] L_LO  = 11'(PADDLE_L_X);
  localparam logic [10:0] L_HI  = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] R_LO  = 11'(PADDLE_R_X);
  localparam logic [10:0] R_HI  = 11'(PADDLE_R_X + PADDLE_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_TICKS - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dh_n, dv_n, pl_n, pr_n;
  logic [3:0] sl_n, sr_n;
  logic [10:0] bx, by, ly, ry;
  logic ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
  // Positions widened by one bit so paddle/ball extents never wrap
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign ly = {1'b0, paddle_l_y};
  assign ry = {1'b0, paddle_r_y};
  assign ov_l = by + BS >= ly && by <= ly + PH;
  assign ov_r = by + BS >= ry && by <= ry + PH;
  assign hit_l = !dir_horiz && ov_l && bx <= L_HI && bx >= L_LO;
  assign hit_r = dir_horiz && ov_r && bx + BS >= R_LO && bx <= R_HI;
  assign miss_l = !dir_horiz && bx == 11'd0;
  assign miss_r = dir_horiz && bx >= H_MAX;
  assign state = st;
  // Next-state, score and direction decisions; a miss takes priority over any bounce
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    dh_n = dir_horiz;
    dv_n = dir_vert;
    sl_n = score_l;
    sr_n = score_r;
    pl_n = 1'b0;
    pr_n = 1'b0;
    case (st)
      IDLE, OVER: if (start) begin
        st_n = SERVE;
        cnt_n = '0;
        sl_n = '0;
        sr_n = '0;
        dh_n = 1'b1;
      end
      SERVE: if (move_tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          st_n = PLAY;
          dv_n = !dir_vert;
        end
      end
      default: if (miss_l || miss_r) begin
        sr_n = score_r + {3'd0, miss_l};
        sl_n = score_l + {3'd0, miss_r};
        pr_n = miss_l;
        pl_n = miss_r;
        dh_n = miss_l;
        cnt_n = '0;
        st_n = (sr_n == WIN || sl_n == WIN) ? OVER : SERVE;
      end else begin
        dv_n = (!dir_vert && by == 11'd0) ? 1'b1 : (dir_vert && by >= V_MAX) ? 1'b0 : dir_vert;
        dh_n = hit_l ? 1'b1 : hit_r ? 1'b0 : dir_horiz;
      end
    endcase
  end
  // Registered outputs; ball is held at centre whenever not in play
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      ball_reset <= 1'b1;
      dir_horiz <= 1'b1;
      dir_vert <= 1'b1;
      score_l <= '0;
      score_r <= '0;
      point_l <= 1'b0;
      point_r <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ball_reset <= st_n != PLAY;
      dir_horiz <= dh_n;
      dir_vert <= dv_n;
      score_l <= sl_n;
      score_r <= sr_n;
      point_l <= pl_n;
      point_r <= pr_n;
      game_over <= st_n == OVER;
    end
  end
endmodule

// File: tb/tb_ball_sequencer.sv
// tb_ball_sequencer: directed and randomized checks of ball_sequencer against a rule-level model
module tb_ball_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, move_tick = 1'b0;
  logic [9:0] ball_x = 10'd320, ball_y = 10'd240, paddle_l_y = 10'd200, paddle_r_y = 10'd200;
  logic ball_reset, dir_horiz, dir_vert, point_l, point_r, game_over;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  int tests = 0, fails = 0;
  int m_st, m_cnt, m_br, m_dh, m_dv, m_sl, m_sr, m_pl, m_pr, m_go;
  int xs[12] = '{0, 20, 25, 30, 31, 320, 594, 600, 609, 619, 623, 624};
  int ys[4] = '{0, 463, 464, 479};

  ball_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_reset(ball_reset), .dir_horiz(dir_horiz), .dir_vert(dir_vert),
    .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_br = 1; m_dh = 1; m_dv = 1;
    m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0; m_go = 0;
  endtask

  // Game rules applied to the inputs present before the coming clock edge
  task automatic model_step();
    int bx, by, ly, ry, dv, dh;
    bx = ball_x; by = ball_y; ly = paddle_l_y; ry = paddle_r_y;
    m_pl = 0; m_pr = 0;
    if (m_st == 0 || m_st == 3) begin
      if (start) begin m_st = 1; m_cnt = 0; m_sl = 0; m_sr = 0; m_dh = 1; end
    end else if (m_st == 1) begin
      if (move_tick) begin
        m_cnt++;
        if (m_cnt == 64) begin m_st = 2; m_dv = 1 - m_dv; end
      end
    end else if (m_dh == 0 && bx == 0) begin
      m_sr++; m_pr = 1; m_dh = 1; m_cnt = 0; m_st = (m_sr == 7) ? 3 : 1;
    end else if (m_dh == 1 && bx >= 624) begin
      m_sl++; m_pl = 1; m_dh = 0; m_cnt = 0; m_st = (m_sl == 7) ? 3 : 1;
    end else begin
      dv = m_dv; dh = m_dh;
      if (m_dv == 0 && by == 0) dv = 1;
      if (m_dv == 1 && by >= 464) dv = 0;
      if (m_dh == 0 && by + 15 >= ly && by <= ly + 80 && bx >= 20 && bx <= 30) dh = 1;
      if (m_dh == 1 && by + 15 >= ry && by <= ry + 80 && bx + 15 >= 609 && bx <= 619) dh = 0;
      m_dv = dv; m_dh = dh;
    end
    m_br = (m_st != 2) ? 1 : 0;
    m_go = (m_st == 3) ? 1 : 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(state), m_st);
    chk({tag, ".ball_reset"}, 32'(ball_reset), m_br);
    chk({tag, ".dir_horiz"}, 32'(dir_horiz), m_dh);
    chk({tag, ".dir_vert"}, 32'(dir_vert), m_dv);
    chk({tag, ".score_l"}, 32'(score_l), m_sl);
    chk({tag, ".score_r"}, 32'(score_r), m_sr);
    chk({tag, ".point_l"}, 32'(point_l), m_pl);
    chk({tag, ".point_r"}, 32'(point_r), m_pr);
    chk({tag, ".game_over"}, 32'(game_over), m_go);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic serve_out();
    for (int i = 0; i < 64; i++) begin
      move_tick = 1'b1; step("serve");
      move_tick = 1'b0; step("serve");
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset");
    start = 1'b1; step("start"); start = 1'b0;
    chk("start_state", 32'(state), 1);
    serve_out();
    chk("release_state", 32'(state), 2);
    chk("release_dir_horiz", 32'(dir_horiz), 1);
    ball_y = 10'd0; step("vbounce");
    chk("vbounce_dv", 32'(dir_vert), 1);
    repeat (5) step("vhold");
    chk("vhold_dv", 32'(dir_vert), 1);
    ball_x = 10'd600; ball_y = 10'd240; paddle_r_y = 10'd200; step("rhit");
    chk("rhit_dh", 32'(dir_horiz), 0);
    ball_x = 10'd30; ball_y = 10'd100; paddle_l_y = 10'd90; step("lhit");
    chk("lhit_dh", 32'(dir_horiz), 1);
    ball_x = 10'd600; ball_y = 10'd240; step("rhit2");
    ball_x = 10'd30; ball_y = 10'd100; paddle_l_y = 10'd300; step("lnohit");
    chk("lnohit_dh", 32'(dir_horiz), 0);
    paddle_l_y = 10'd90; step("lhit2");
    ball_x = 10'd624; paddle_r_y = 10'd0; step("rmiss");
    chk("rmiss_point_l", 32'(point_l), 1);
    chk("rmiss_score_l", 32'(score_l), 1);
    chk("rmiss_state", 32'(state), 1);
    chk("rmiss_dh", 32'(dir_horiz), 0);
    ball_x = 10'd320; step("after_point");
    chk("pulse_end", 32'(point_l), 0);
    for (int r = 0; r < 7 && m_go == 0; r++) begin
      serve_out();
      if (m_dh == 1) begin
        ball_x = 10'd600; ball_y = 10'd240; paddle_r_y = 10'd200; step("rally_rhit");
      end
      ball_x = 10'd0; ball_y = 10'd0; step("lmiss");
      chk("lmiss_point_r", 32'(point_r), 1);
      ball_x = 10'd320; ball_y = 10'd240;
    end
    chk("win_game_over", 32'(game_over), 1);
    chk("win_score_r", 32'(score_r), 7);
    chk("win_state", 32'(state), 3);
    ball_x = 10'd0;
    repeat (3) step("frozen");
    start = 1'b1; step("restart"); start = 1'b0;
    chk("restart_state", 32'(state), 1);
    chk("restart_score_r", 32'(score_r), 0);
    serve_out();
    ball_x = 10'd320; ball_y = 10'd200; step("midplay");
    #2 reset = 1'b1;
    #1 model_reset();
    chk_all("async_reset");
    chk("async_state", 32'(state), 0);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 49) == 0);
      move_tick = move_tick ? 1'b0 : 1'($urandom_range(0, 1));
      ball_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 639)) : 10'(xs[$urandom_range(0, 11)]);
      ball_y = ($urandom_range(0, 2) == 0) ? 10'(ys[$urandom_range(0, 3)]) : 10'($urandom_range(0, 479));
      paddle_l_y = 10'($urandom_range(0, 399));
      paddle_r_y = 10'($urandom_range(0, 399));
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
